// File: rtl/pi_gpio_led_sw_bridge.sv
// Bridge between the Pi GPIO emulation bus and board switches/LEDs: switches are
// synchronised, debounced and flagged onto mapped gpio_i pins; LEDs latch gpio_o and are PWM-dimmed.
module pi_gpio_led_sw_bridge #(
  parameter int GPIO_W = 28,
  parameter int N_SW = 16,
  parameter int N_LED = 16,
  parameter logic [5*N_SW-1:0] SW_MAP = {5'd27, 5'd26, 5'd25, 5'd24, 5'd23, 5'd22,
                                         5'd11, 5'd10, 5'd9, 5'd8, 5'd7, 5'd6,
                                         5'd5, 5'd4, 5'd3, 5'd2},
  parameter logic [5*N_LED-1:0] LED_MAP = {5'd27, 5'd26, 5'd25, 5'd24, 5'd23, 5'd22,
                                           5'd11, 5'd10, 5'd9, 5'd8, 5'd7, 5'd6,
                                           5'd5, 5'd4, 5'd3, 5'd2},
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk_peripheral,
  input  logic                reset,
  input  logic [GPIO_W-1:0]   gpio_o,
  input  logic [GPIO_W-1:0]   gpio_t,
  output logic [GPIO_W-1:0]   gpio_i,
  input  logic [N_SW-1:0]     sw,
  output logic [N_LED-1:0]    led,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [N_SW-1:0]     sw_clr,
  input  logic                irq_en,
  output logic [N_SW-1:0]     sw_changed,
  output logic                irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [PWM_BITS-1:0] ALL_ONES = '1;

  logic [N_SW-1:0]     sync1_q;
  logic [N_SW-1:0]     sw_s_q;
  logic [N_SW-1:0]     stable_q, stable_d;
  logic [N_SW-1:0]     sw_changed_q, sw_changed_d;
  logic [GPIO_W-1:0]   gpio_i_q, gpio_i_d;
  logic [N_LED-1:0]    led_latch_q, led_latch_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, bri_q;
  logic                irq_q;
  logic                on_ph;

  // Switch set driving a given pin; several switches on one pin OR together.
  function automatic logic [N_SW-1:0] sw_sel(input int pin);
    logic [N_SW-1:0] sel;
    sel = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (int'(SW_MAP[5*i +: 5]) == pin) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      sync1_q <= '0;
      sw_s_q  <= '0;
    end else begin
      sync1_q <= sw;
      sw_s_q  <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      localparam int PIN = int'(SW_MAP[5*gi +: 5]);
      if (PIN >= GPIO_W) begin : g_bad_map
        $error("SW_MAP entry %0d selects pin %0d outside the GPIO bus", gi, PIN);
      end

      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign stable_d[gi] = sw_s_q[gi];
      end else begin : g_dbnc
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             stable_nxt;

        // Counter tracks how long sw_s has disagreed with the accepted level.
        always_comb begin
          cnt_d      = '0;
          stable_nxt = stable_q[gi];
          if (sw_s_q[gi] != stable_q[gi]) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_nxt = sw_s_q[gi];
            else cnt_d = cnt_q + 1'b1;
          end
        end

        always_ff @(posedge clk_peripheral) begin
          if (reset) cnt_q <= '0;
          else       cnt_q <= cnt_d;
        end

        assign stable_d[gi] = stable_nxt;
      end
    end

    for (gi = 0; gi < GPIO_W; gi++) begin : g_pin
      localparam logic [N_SW-1:0] SEL = sw_sel(gi);
      assign gpio_i_d[gi] = |(stable_q & SEL);
    end

    for (gi = 0; gi < N_LED; gi++) begin : g_led
      localparam int PIN = int'(LED_MAP[5*gi +: 5]);
      if (PIN >= GPIO_W) begin : g_bad_map
        $error("LED_MAP entry %0d selects pin %0d outside the GPIO bus", gi, PIN);
        assign led_latch_d[gi] = led_latch_q[gi];
      end else begin : g_ok
        assign led_latch_d[gi] = gpio_t[PIN] ? gpio_o[PIN] : led_latch_q[gi];
      end
    end
  endgenerate

  // A new toggle outranks a clear arriving in the same cycle.
  assign sw_changed_d = (sw_changed_q & ~sw_clr) | (stable_d ^ stable_q);

  assign on_ph = (bri_q == ALL_ONES) | (pwm_cnt_q < bri_q);
  assign led_d = led_latch_q & {N_LED{on_ph}};

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      stable_q     <= '0;
      sw_changed_q <= '0;
      irq_q        <= 1'b0;
      gpio_i_q     <= '0;
      led_latch_q  <= '0;
      led_q        <= '0;
      pwm_cnt_q    <= '0;
      bri_q        <= ALL_ONES;
    end else begin
      stable_q     <= stable_d;
      sw_changed_q <= sw_changed_d;
      irq_q        <= (|sw_changed_q) & irq_en;
      gpio_i_q     <= gpio_i_d;
      led_latch_q  <= led_latch_d;
      led_q        <= led_d;
      pwm_cnt_q    <= pwm_cnt_q + 1'b1;
      // Brightness is only sampled at the period boundary to avoid torn duty cycles.
      if (pwm_cnt_q == ALL_ONES) bri_q <= brightness;
    end
  end

  // Pins not claimed by any LED are legitimately ignored.
  logic unused_pins;
  assign unused_pins = ^{gpio_o, gpio_t};

  assign gpio_i     = gpio_i_q;
  assign led        = led_q;
  assign sw_changed = sw_changed_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_pi_gpio_led_sw_bridge.sv
// Self-checking bench for pi_gpio_led_sw_bridge: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_pi_gpio_led_sw_bridge;

  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] gpio_o, gpio_t, gpio_i;
  logic [15:0] sw, led, sw_clr, sw_changed;
  logic [3:0]  brightness;
  logic        irq_en, irq;

  always #5 clk = ~clk;

  pi_gpio_led_sw_bridge #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk_peripheral(clk),
    .reset(reset),
    .gpio_o(gpio_o),
    .gpio_t(gpio_t),
    .gpio_i(gpio_i),
    .sw(sw),
    .led(led),
    .brightness(brightness),
    .sw_clr(sw_clr),
    .irq_en(irq_en),
    .sw_changed(sw_changed),
    .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Default board wiring: entries 0..9 -> pins 2..11, entries 10..15 -> pins 22..27.
  function automatic int map_pin(input int i);
    return (i < 10) ? i + 2 : i + 12;
  endfunction

  // Model state: two raw-sample delays, a window of the last DC synchronised
  // samples per switch, and the visible outputs.
  logic [15:0]   m_r1, m_r2, m_stable, m_changed, m_latch, m_led;
  logic [DC-1:0] m_hist [16];
  logic [27:0]   m_gpio_i;
  logic          m_irq;
  int            m_pwm, m_bri;

  task automatic model_edge();
    logic [15:0] nst, tog, nled;
    logic [27:0] ngp;
    logic        on;
    if (reset) begin
      m_r1 = '0; m_r2 = '0; m_stable = '0; m_changed = '0; m_latch = '0; m_led = '0;
      m_gpio_i = '0; m_irq = 1'b0; m_pwm = 0; m_bri = 15;
      for (int i = 0; i < 16; i++) m_hist[i] = '0;
    end else begin
      ngp = '0;
      for (int i = 0; i < 16; i++) if (m_stable[i]) ngp[map_pin(i)] = 1'b1;
      // A switch flips once its last DC synchronised samples all disagree with it.
      nst = m_stable;
      for (int i = 0; i < 16; i++) begin
        m_hist[i] = {m_hist[i][DC-2:0], m_r2[i]};
        if (m_hist[i] == {DC{~m_stable[i]}}) nst[i] = ~m_stable[i];
      end
      tog  = nst ^ m_stable;
      on   = (m_bri == 15) || (m_pwm < m_bri);
      nled = on ? m_latch : 16'h0;
      m_irq     = (|m_changed) & irq_en;
      m_changed = (m_changed & ~sw_clr) | tog;
      for (int j = 0; j < 16; j++) if (gpio_t[map_pin(j)]) m_latch[j] = gpio_o[map_pin(j)];
      if (m_pwm == 15) m_bri = int'(brightness);
      m_pwm    = (m_pwm + 1) % 16;
      m_stable = nst;
      m_gpio_i = ngp;
      m_led    = nled;
      m_r2     = m_r1;
      m_r1     = sw;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("gpio_i", 32'(gpio_i), 32'(m_gpio_i));
    chk("sw_changed", 32'(sw_changed), 32'(m_changed));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, hi, idx;
    logic found;

    reset = 1'b1; sw = 16'hFFFF; gpio_t = '1; gpio_o = '1;
    brightness = 4'hF; sw_clr = '0; irq_en = 1'b0;
    repeat (3) begin
      step();
      chk("rst_led", 32'(led), 0);
      chk("rst_gpio_i", 32'(gpio_i), 0);
      chk("rst_flags", 32'(sw_changed), 0);
      chk("rst_irq", 32'(irq), 0);
    end
    reset = 1'b0; sw = '0; gpio_t = '0; gpio_o = '0;
    repeat (20) step();

    // Debounce latency and glitch rejection
    sw[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (gpio_i[2]) begin lat = k; break; end
    end
    chk("dbnc_latency", 32'(lat), 11);
    chk("dbnc_flag", 32'(sw_changed[0]), 1);
    sw_clr = 16'h0001; step(); sw_clr = '0;
    sw[0] = 1'b0; repeat (7) step();
    sw[0] = 1'b1; repeat (20) step();
    chk("glitch_gpio_i", 32'(gpio_i[2]), 1);
    chk("glitch_flag", 32'(sw_changed[0]), 0);

    // Default mapping
    sw = 16'h8001; repeat (15) step();
    chk("map_8001", 32'(gpio_i), 32'h0800_0004);
    sw = 16'hFFFF; repeat (15) step();
    chk("map_unmapped", 32'(gpio_i & 28'h03F_F003), 0);
    chk("map_ffff", 32'(gpio_i), 32'h0FC0_0FFC);
    sw = 16'h8001; repeat (15) step();

    // LED latch holds after gpio_t drops
    gpio_o[22] = 1'b1; gpio_t[22] = 1'b1; step();
    gpio_o = '0; gpio_t = '0; repeat (5) step();
    chk("led10_held", 32'(led[10]), 1);
    chk("led_low_bits", 32'(led[9:0]), 0);

    // PWM duty
    gpio_o[2] = 1'b1; gpio_t[2] = 1'b1; step();
    gpio_o = '0; gpio_t = '0;
    brightness = 4'd4; repeat (40) step();
    hi = 0; repeat (64) begin step(); hi += int'(led[0]); end
    chk("pwm_duty4", 32'(hi), 16);
    brightness = 4'd15; repeat (20) step();
    hi = 0; repeat (32) begin step(); hi += int'(led[0]); end
    chk("pwm_duty15", 32'(hi), 32);
    brightness = 4'd0; repeat (20) step();
    hi = 0; repeat (32) begin step(); hi += int'(led[0]); end
    chk("pwm_duty0", 32'(hi), 0);
    brightness = 4'd15; repeat (20) step();

    // IRQ, set-wins-over-clear, clear path
    irq_en = 1'b1;
    sw_clr = '1; step(); sw_clr = '0; step();
    sw[3] = 1'b1; sw_clr = 16'h0008; found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sw_changed[3]) begin found = 1'b1; break; end
    end
    chk("set_wins", 32'(found), 1);
    sw_clr = '0; step();
    chk("irq_set", 32'(irq), 1);
    chk("flag_hold", 32'(sw_changed[3]), 1);
    sw_clr = 16'h0008; step(); sw_clr = '0;
    chk("clr_flag", 32'(sw_changed[3]), 0);
    chk("irq_lag", 32'(irq), 1);
    step();
    chk("irq_clr", 32'(irq), 0);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        idx = int'($urandom_range(0, 15));
        sw[idx] = ~sw[idx];
      end
      gpio_t = ($urandom_range(0, 3) == 0) ? 28'($urandom) : 28'h0;
      gpio_o = 28'($urandom);
      if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
      sw_clr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
      if ($urandom_range(0, 99) == 0) irq_en = ~irq_en;
      reset = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
